subservient_sram_arbiter: RTL and testbench
===========================================

# subservient_sram_arbiter

Shares the single sky130 1rw1r 32x256 OpenRAM macro (1 kB) between the subservient core's 8-bit SRAM interface and a 32-bit Wishbone debug/loader port. Sits between the `subservient` SRAM pins and the macro, replacing the ad-hoc byte-lane adapter. The core has absolute priority and is never stalled. Wishbone accesses are slotted into idle macro-port cycles, and blocked cycles are counted.

## Interface
Parameters:
- AW, 10, core byte-address width; macro word address is addr[9:2], with upper bits ignored on the core side.

Ports:
- i_clk  in  1  clock for block and macro
- i_rst  in  1  synchronous, active-high reset
- i_sram_waddr  in  AW  core write byte address
- i_sram_wdata  in  8  core write data
- i_sram_wen  in  1  core write strobe
- i_sram_raddr  in  AW  core read byte address
- i_sram_ren  in  1  core read strobe
- o_sram_rdata  out  8  core read byte, valid the cycle after i_sram_ren
- i_wb_adr  in  32  Wishbone byte address
- i_wb_dat  in  32  Wishbone write data
- i_wb_sel  in  4  Wishbone byte enables
- i_wb_we  in  1  Wishbone write
- i_wb_stb  in  1  Wishbone request (classic, held until ack)
- o_wb_rdt  out  32  Wishbone read data, registered
- o_wb_ack  out  1  single-cycle ack
- o_csb0, o_web0  out  1 each  macro port 0 select (active low) and write-enable (always 0)
- o_wmask0  out  4  port 0 byte mask
- o_addr0  out  8  port 0 word address
- o_din0  out  32  port 0 write data
- o_csb1  out  1  port 1 select (active low)
- o_addr1  out  8  port 1 word address
- i_dout1  in  32  port 1 read data, valid one cycle after issue
- o_conflicts  out  16  saturating count of Wishbone-blocked cycles

## Operation
- Port 0 is write-only:
  - Core write: o_wmask0 = 1<<waddr[1:0], o_din0 = {4{wdata}}, o_addr0 = waddr[9:2].
  - Wishbone write: o_wmask0 = sel, o_din0 = dat, o_addr0 = adr[9:2].
- Port 1 is read-only. Core read: o_addr1 = raddr[9:2]. A registered bsel <= raddr[1:0] is captured when i_sram_ren=1. o_sram_rdata = i_dout1[bsel*8+:8].
- Wishbone FSM states:
  - IDLE, with stb=1:
    - If adr[31:10]≠0 (out of range), go to ACK with no macro access; rdt is loaded with 0.
    - Else if we=1 and i_sram_wen=0, issue the write on port 0 and go to ACK.
    - Else if we=0, i_sram_ren=0, and not (i_sram_wen=1 and waddr[9:2]==adr[9:2]), issue the read on port 1 and go to RD_WAIT.
    - Otherwise stay in IDLE and count a conflict.
  - RD_WAIT: o_wb_rdt <= i_dout1; go to ACK.
  - ACK: o_wb_ack=1 for this cycle only; go to IDLE.
- A new request is accepted only in IDLE, which is always at least one cycle after ack. The master drops stb in that cycle.
- Core port muxing is combinational from the core strobes. The Wishbone drive is used only in the cycle the FSM issues.
- o_conflicts increments by 1 per blocked IDLE+stb cycle and saturates at 0xFFFF.
- A core write and a core read of the same word in the same cycle get no protection. Read data is undefined, matching the macro.

## Timing
- Reset values: o_csb0=1, o_csb1=1, o_web0=0, o_wmask0=0, o_addr0=0, o_din0=0, o_addr1=0, o_wb_ack=0, o_wb_rdt=0, o_conflicts=0, bsel=0, FSM=IDLE.
- Core read: ren in cycle N gives o_sram_rdata valid in N+1. Core write: committed at the end of cycle N. The core side has zero added latency.
- Wishbone write, unblocked: stb seen in cycle N, issued in N, ack in N+1.
- Wishbone read, unblocked: issued in N, captured in N+1, ack in N+2 with o_wb_rdt already valid.
- Out-of-range access: ack in N+1, rdt=0.
- Each blocked cycle adds exactly one cycle of latency. There is no timeout.
- Reset mid-transaction: the FSM goes to IDLE at the next edge, no ack is issued, and the request is dropped. The master retries.

## Test plan
- Load 1 kB via Wishbone writes with sel=1111 and core idle → each ack 1 cycle after stb. Then Wishbone reads return identical words, ack at N+2, o_conflicts=0.
- Wishbone write adr=0x10, dat=0xAABBCCDD, sel=0101 over 0x11223344 → Wishbone read 0x10 returns 0x11BB33DD.
- Core writes byte 0x5A to addr 0x23 → word 8 lane 3 changes; a core read of 0x23 returns 0x5A on the next cycle.
- Wishbone read held while core ren=1 for 5 consecutive cycles → o_conflicts=5, ack at cycle N+7. Core read data is unaffected.
- Wishbone read adr=0x40 with core write to 0x42 in the same cycle → read deferred one cycle and returns the post-write word.
- Wishbone read adr=0x400 → ack at N+1, rdt=0, csb0=csb1=1. Reset asserted in RD_WAIT → no ack, all outputs at their reset values.

Source files
------------

// File: rtl/subservient_sram_arbiter.sv
// rtl/subservient_sram_arbiter.sv - shares one 1rw1r 32x256 SRAM macro between the core byte port and a Wishbone port
//
// Purpose:
//   The subservient core's 8-bit SRAM interface owns the macro whenever it
//   strobes. It is never stalled and sees no added latency. A 32-bit
//   Wishbone debug/loader port borrows macro port 0 (write) or port 1 (read)
//   only in cycles the core leaves free. Every cycle a pending Wishbone
//   request is held off is counted in a saturating 16-bit counter.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_sram_waddr/wdata/wen             core byte write
//   i_sram_raddr/ren, o_sram_rdata     core byte read (data valid next cycle)
//   i_wb_adr/dat/sel/we/stb            Wishbone classic request, held until ack
//   o_wb_rdt, o_wb_ack                 registered read data, single-cycle ack
//   o_csb0/web0/wmask0/addr0/din0      macro port 0 (write only, web0 tied 0)
//   o_csb1/addr1, i_dout1              macro port 1 (read only, data next cycle)
//   o_conflicts                        saturating count of blocked Wishbone cycles
//
// AW must be at least 10. Core address bits above bit 9 are ignored.

module subservient_sram_arbiter #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_sram_waddr,
    input  logic [7:0]    i_sram_wdata,
    input  logic          i_sram_wen,
    input  logic [AW-1:0] i_sram_raddr,
    input  logic          i_sram_ren,
    output logic [7:0]    o_sram_rdata,
    input  logic [31:0]   i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_stb,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_csb0,
    output logic          o_web0,
    output logic [3:0]    o_wmask0,
    output logic [7:0]    o_addr0,
    output logic [31:0]   o_din0,
    output logic          o_csb1,
    output logic [7:0]    o_addr1,
    input  logic [31:0]   i_dout1,
    output logic [15:0]   o_conflicts
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  bsel;

    logic        core_wr;
    logic        core_rd;
    logic        wb_req;
    logic        wb_in_range;
    logic        wb_same_word;
    logic        wb_oor;
    logic        wb_wr_go;
    logic        wb_rd_go;
    logic        wb_block;

    // Wishbone byte-offset bits never reach the macro.
    logic        unused_wb_adr;
    assign unused_wb_adr = &{1'b0, i_wb_adr[1:0]};

    // Everything is gated by reset so a strobe seen during reset never
    // reaches the macro and the port outputs sit at their idle values.
    assign core_wr      = !i_rst && i_sram_wen;
    assign core_rd      = !i_rst && i_sram_ren;
    assign wb_req       = !i_rst && (state == S_IDLE) && i_wb_stb;
    assign wb_in_range  = (i_wb_adr[31:10] == 22'd0);

    // A core write to the very word the Wishbone read targets would leave
    // the read data undefined in the macro, so the read waits a cycle and
    // returns the post-write word instead.
    assign wb_same_word = i_sram_wen && (i_sram_waddr[9:2] == i_wb_adr[9:2]);

    assign wb_oor   = wb_req && !wb_in_range;
    assign wb_wr_go = wb_req && wb_in_range && i_wb_we && !i_sram_wen;
    assign wb_rd_go = wb_req && wb_in_range && !i_wb_we && !i_sram_ren && !wb_same_word;
    assign wb_block = wb_req && wb_in_range && !wb_wr_go && !wb_rd_go;

    // Port 0: write only. Core has priority; Wishbone drives only on issue.
    assign o_web0 = 1'b0;

    always_comb begin
        o_csb0   = 1'b1;
        o_wmask0 = 4'b0000;
        o_addr0  = 8'd0;
        o_din0   = 32'd0;
        if (core_wr) begin
            o_csb0   = 1'b0;
            o_wmask0 = 4'b0001 << i_sram_waddr[1:0];
            o_addr0  = i_sram_waddr[9:2];
            o_din0   = {4{i_sram_wdata}};
        end else if (wb_wr_go) begin
            o_csb0   = 1'b0;
            o_wmask0 = i_wb_sel;
            o_addr0  = i_wb_adr[9:2];
            o_din0   = i_wb_dat;
        end
    end

    // Port 1: read only.
    always_comb begin
        o_csb1  = 1'b1;
        o_addr1 = 8'd0;
        if (core_rd) begin
            o_csb1  = 1'b0;
            o_addr1 = i_sram_raddr[9:2];
        end else if (wb_rd_go) begin
            o_csb1  = 1'b0;
            o_addr1 = i_wb_adr[9:2];
        end
    end

    // Byte lane of the last core read selects from the word the macro
    // returns one cycle later.
    assign o_sram_rdata = i_dout1[{bsel, 3'b000} +: 8];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wb_oor || wb_wr_go) begin
                    state_nxt = S_ACK;
                end else if (wb_rd_go) begin
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: state_nxt = S_ACK;
            S_ACK:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign o_wb_ack = !i_rst && (state == S_ACK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            bsel        <= 2'd0;
            o_wb_rdt    <= 32'd0;
            o_conflicts <= 16'd0;
        end else begin
            state <= state_nxt;
            if (i_sram_ren) begin
                bsel <= i_sram_raddr[1:0];
            end
            if (state == S_RD_WAIT) begin
                o_wb_rdt <= i_dout1;
            end else if (wb_oor) begin
                o_wb_rdt <= 32'd0;
            end
            if (wb_block && (o_conflicts != 16'hFFFF)) begin
                o_conflicts <= o_conflicts + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// tb/tb_subservient_sram_arbiter.sv - directed self-checking bench for subservient_sram_arbiter
module tb_subservient_sram_arbiter;

    logic        clk;
    logic        rst;
    logic [9:0]  sram_waddr;
    logic [7:0]  sram_wdata;
    logic        sram_wen;
    logic [9:0]  sram_raddr;
    logic        sram_ren;
    logic [7:0]  sram_rdata;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] dout1;
    logic [15:0] conflicts;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem  [256];
    logic [31:0] refm [256];
    logic        first_csb0;
    logic        first_csb1;

    subservient_sram_arbiter #(.AW(10)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sram_waddr (sram_waddr),
        .i_sram_wdata (sram_wdata),
        .i_sram_wen   (sram_wen),
        .i_sram_raddr (sram_raddr),
        .i_sram_ren   (sram_ren),
        .o_sram_rdata (sram_rdata),
        .i_wb_adr     (wb_adr),
        .i_wb_dat     (wb_dat),
        .i_wb_sel     (wb_sel),
        .i_wb_we      (wb_we),
        .i_wb_stb     (wb_stb),
        .o_wb_rdt     (wb_rdt),
        .o_wb_ack     (wb_ack),
        .o_csb0       (csb0),
        .o_web0       (web0),
        .o_wmask0     (wmask0),
        .o_addr0      (addr0),
        .o_din0       (din0),
        .o_csb1       (csb1),
        .o_addr1      (addr1),
        .i_dout1      (dout1),
        .o_conflicts  (conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1rw1r macro: masked write on port 0, registered read on port 1.
    initial dout1 = 32'd0;
    always @(posedge clk) begin
        if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end
        end
        if (!csb1) dout1 <= mem[addr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_byte(input int a);
        logic [31:0] w;
        w = refm[a / 4];
        return w[(a % 4) * 8 +: 8];
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_csb0"},   {31'd0, csb0},   32'd1);
        chk({tag, "_csb1"},   {31'd0, csb1},   32'd1);
        chk({tag, "_web0"},   {31'd0, web0},   32'd0);
        chk({tag, "_wmask0"}, {28'd0, wmask0}, 32'd0);
        chk({tag, "_addr0"},  {24'd0, addr0},  32'd0);
        chk({tag, "_din0"},   din0,            32'd0);
        chk({tag, "_addr1"},  {24'd0, addr1},  32'd0);
        chk({tag, "_ack"},    {31'd0, wb_ack}, 32'd0);
        chk({tag, "_rdt"},    wb_rdt,          32'd0);
        chk({tag, "_confl"},  {16'd0, conflicts}, 32'd0);
    endtask

    // Starts at posedge+1; lat counts cycles from request to ack (99 on timeout).
    task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, output int lat, output logic [31:0] rdt);
        logic done;
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_stb = 1'b1;
        lat = 0; done = 1'b0; rdt = 32'd0;
        while (!done) begin
            @(negedge clk);
            if (lat == 0) begin
                first_csb0 = csb0;
                first_csb1 = csb1;
            end
            if (wb_ack) begin
                done = 1'b1; rdt = wb_rdt; wb_stb = 1'b0; wb_we = 1'b0;
            end else if (lat >= 20) begin
                done = 1'b1; lat = 99; wb_stb = 1'b0;
            end
            step();
            if (!done) lat++;
        end
    endtask

    initial begin
        int          lat;
        int          ack_c;
        logic [31:0] rd;
        logic [7:0]  b;

        rst = 1'b1;
        sram_waddr = '0; sram_wdata = '0; sram_wen = 1'b0;
        sram_raddr = '0; sram_ren = 1'b0;
        wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_stb = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        repeat (3) step();
        @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // Fill the whole macro over Wishbone, then read every word back.
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            refm[i] = {b, ~b, b ^ 8'hA5, b ^ 8'h3C};
            wb_xfer(i * 4, refm[i], 4'hF, 1'b1, lat, rd);
            chk("load_lat", lat, 1);
        end
        for (int i = 0; i < 256; i++) begin
            wb_xfer(i * 4, 32'd0, 4'h0, 1'b0, lat, rd);
            chk("read_lat", lat, 2);
            chk("read_data", rd, refm[i]);
        end
        chk("load_conflicts", {16'd0, conflicts}, 32'd0);

        // Partial-byte Wishbone write.
        wb_xfer(32'h10, 32'h11223344, 4'hF, 1'b1, lat, rd);
        wb_xfer(32'h10, 32'hAABBCCDD, 4'b0101, 1'b1, lat, rd);
        wb_xfer(32'h10, 32'd0, 4'h0, 1'b0, lat, rd);
        chk("sel_merge", rd, 32'h11BB33DD);
        refm[4] = 32'h11BB33DD;

        // Core byte write then byte read.
        sram_wen = 1'b1; sram_waddr = 10'h023; sram_wdata = 8'h5A;
        @(negedge clk);
        chk("cw_csb0",  {31'd0, csb0},   32'd0);
        chk("cw_wmask", {28'd0, wmask0}, 32'h8);
        chk("cw_addr0", {24'd0, addr0},  32'd8);
        chk("cw_din0",  din0,            32'h5A5A5A5A);
        step();
        sram_wen = 1'b0; sram_ren = 1'b1; sram_raddr = 10'h023;
        @(negedge clk);
        chk("cr_csb1",  {31'd0, csb1},  32'd0);
        chk("cr_addr1", {24'd0, addr1}, 32'd8);
        step();
        sram_ren = 1'b0;
        @(negedge clk);
        chk("cr_rdata", {24'd0, sram_rdata}, 32'h5A);
        refm[8][31:24] = 8'h5A;
        step();
        wb_xfer(32'h20, 32'd0, 4'h0, 1'b0, lat, rd);
        chk("cw_wb_word", rd, refm[8]);

        // Wishbone read blocked by five consecutive core reads of 0x20..0x24.
        wb_adr = 32'h20; wb_we = 1'b0; wb_stb = 1'b1;
        sram_ren = 1'b1; sram_raddr = 10'h020;
        ack_c = -1; rd = 32'd0;
        for (int c = 0; c < 12 && ack_c < 0; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 5) chk("blk_core_rdata", {24'd0, sram_rdata}, {24'd0, ref_byte(32'h20 + c - 1)});
            if (wb_ack) begin
                ack_c = c; rd = wb_rdt; wb_stb = 1'b0;
            end
            step();
            if (c + 1 < 5) sram_raddr = 10'h020 + 10'(c + 1);
            else sram_ren = 1'b0;
        end
        chk("blk_ack_cycle", ack_c, 7);
        chk("blk_rdt", rd, refm[8]);
        chk("blk_conflicts", {16'd0, conflicts}, 32'd5);

        // Wishbone read of word 16 racing a core write to byte 0x42.
        wb_adr = 32'h40; wb_we = 1'b0; wb_stb = 1'b1;
        sram_wen = 1'b1; sram_waddr = 10'h042; sram_wdata = 8'h77;
        ack_c = -1; rd = 32'd0;
        for (int c = 0; c < 10 && ack_c < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("race_defer_csb1", {31'd0, csb1}, 32'd1);
            if (wb_ack) begin
                ack_c = c; rd = wb_rdt; wb_stb = 1'b0;
            end
            step();
            sram_wen = 1'b0;
        end
        refm[16][23:16] = 8'h77;
        chk("race_ack_cycle", ack_c, 3);
        chk("race_rdt", rd, refm[16]);
        chk("race_conflicts", {16'd0, conflicts}, 32'd6);

        // Reset while the read is in RD_WAIT: no ack, everything back to reset.
        wb_adr = 32'h4; wb_we = 1'b0; wb_stb = 1'b1;
        @(negedge clk);
        chk("rst_issue_csb1", {31'd0, csb1}, 32'd0);
        step();
        rst = 1'b1; wb_stb = 1'b0;
        @(negedge clk);
        chk("rst_no_ack", {31'd0, wb_ack}, 32'd0);
        step();
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        step();
        rst = 1'b0;
        wb_xfer(32'h4, 32'd0, 4'h0, 1'b0, lat, rd);
        chk("retry_lat", lat, 2);
        chk("retry_rdt", rd, refm[1]);

        // Out-of-range read: no macro access, quick ack, zero data.
        wb_xfer(32'h400, 32'd0, 4'h0, 1'b0, lat, rd);
        chk("oor_lat", lat, 1);
        chk("oor_rdt", rd, 32'd0);
        chk("oor_csb0", {31'd0, first_csb0}, 32'd1);
        chk("oor_csb1", {31'd0, first_csb1}, 32'd1);
        chk("oor_conflicts", {16'd0, conflicts}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
